decode_stage: RTL and testbench

Instruction-decode stage of the MIPS pipeline, placed between the IF/ID latch and the execute stage. It drives the register-file read addresses, decodes control, sign-extends the immediate and captures everything in the ID/EX pipeline register. It also detects load-use hazards against the instruction it holds in ID/EX and inserts one bubble.

---
 rtl/decode_stage_pkg.sv | 28 ++
 rtl/control_decoder.sv | 45 ++++
 rtl/decode_stage.sv | 120 ++++++++++++
 tb/tb_decode_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU class encodings and the
// control bundle carried from decode into the ID/EX register.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       aluSrc;
    logic       regDst;
    logic       branch;
    logic [1:0] aluOp;
  } ctrlT;

  localparam ctrlT CTRL_NONE = '0;

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decoder: produces the control bundle and flags any
// opcode outside the supported subset as illegal (with all control cleared).
module control_decoder
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  output ctrlT       ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
        ctrl.aluOp    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.regWrite = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.memtoReg = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluOp  = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALUOP_ADD;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register-file addressing, control decode,
// immediate sign extension, load-use stall detection and the ID/EX register.
module decode_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCPlus4,
  input  logic        InValid,
  input  logic        Flush,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  output logic        Stall,
  output logic        ExValid,
  output logic        ExRegWrite,
  output logic        ExMemRead,
  output logic        ExMemWrite,
  output logic        ExMemtoReg,
  output logic        ExALUSrc,
  output logic        ExRegDst,
  output logic        ExBranch,
  output logic        ExIllegal,
  output logic [1:0]  ExALUOp,
  output logic [31:0] ExPCPlus4,
  output logic [31:0] ExReadData1,
  output logic [31:0] ExReadData2,
  output logic [31:0] ExImmediate,
  output logic [4:0]  ExRs,
  output logic [4:0]  ExRt,
  output logic [4:0]  ExRd
);

  function automatic logic signed [31:0] signExtend(input logic [15:0] imm);
    logic signed [15:0] simm;
    simm = imm;
    return 32'(simm);
  endfunction

  logic [4:0]         rs_p0, rt_p0, rd_p0;
  ctrlT               ctrl_p0;
  logic               illegal_p0;
  logic signed [31:0] imm_p0;
  logic               hazard_p0;

  ctrlT               ctrl_p1;
  logic               illegal_p1;
  logic               vld_p1;
  logic [31:0]        pc_p1, rd1_p1, rd2_p1;
  logic signed [31:0] imm_p1;
  logic [4:0]         rs_p1, rt_p1, rd_p1;

  assign rs_p0  = Instruction[25:21];
  assign rt_p0  = Instruction[20:16];
  assign rd_p0  = Instruction[15:11];
  assign imm_p0 = signExtend(Instruction[15:0]);

  assign ReadRegister1 = rs_p0;
  assign ReadRegister2 = rt_p0;

  control_decoder uDecoder (
    .opcode  (Instruction[31:26]),
    .ctrl    (ctrl_p0),
    .illegal (illegal_p0)
  );

  // Load-use check against the instruction now in EX; checked for every
  // opcode, so I-type rt matches give harmless extra stalls.
  assign hazard_p0 = vld_p1 & ctrl_p1.memRead & (rt_p1 != 5'd0) & InValid &
                     ((rt_p1 == rs_p0) | (rt_p1 == rt_p0));
  assign Stall     = hazard_p0 & ~Flush;

  // ---- ID/EX boundary: bubbles carry no control and zeroed datapath ----
  always_ff @(posedge clk) begin
    if (Reset || Flush || Stall || !InValid) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= CTRL_NONE;
      illegal_p1 <= 1'b0;
      pc_p1      <= '0;
      rd1_p1     <= '0;
      rd2_p1     <= '0;
      imm_p1     <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
    end else begin
      vld_p1     <= 1'b1;
      ctrl_p1    <= ctrl_p0;
      illegal_p1 <= illegal_p0;
      pc_p1      <= PCPlus4;
      rd1_p1     <= ReadData1;
      rd2_p1     <= ReadData2;
      imm_p1     <= imm_p0;
      rs_p1      <= rs_p0;
      rt_p1      <= rt_p0;
      rd_p1      <= rd_p0;
    end
  end

  assign ExValid     = vld_p1;
  assign ExRegWrite  = ctrl_p1.regWrite;
  assign ExMemRead   = ctrl_p1.memRead;
  assign ExMemWrite  = ctrl_p1.memWrite;
  assign ExMemtoReg  = ctrl_p1.memtoReg;
  assign ExALUSrc    = ctrl_p1.aluSrc;
  assign ExRegDst    = ctrl_p1.regDst;
  assign ExBranch    = ctrl_p1.branch;
  assign ExALUOp     = ctrl_p1.aluOp;
  assign ExIllegal   = illegal_p1;
  assign ExPCPlus4   = pc_p1;
  assign ExReadData1 = rd1_p1;
  assign ExReadData2 = rd2_p1;
  assign ExImmediate = imm_p1;
  assign ExRs        = rs_p1;
  assign ExRt        = rt_p1;
  assign ExRd        = rd_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a reference model pushes the expected
// ID/EX contents per cycle into a queue, popped and compared after each edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        Reset, InValid, Flush;
  logic [31:0] Instruction, PCPlus4, ReadData1, ReadData2;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic        Stall;
  logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg;
  logic        ExALUSrc, ExRegDst, ExBranch, ExIllegal;
  logic [1:0]  ExALUOp;
  logic [31:0] ExPCPlus4, ExReadData1, ExReadData2, ExImmediate;
  logic [4:0]  ExRs, ExRt, ExRd;

  typedef logic [153:0] busT;
  localparam int B_VALID = 153;
  localparam int B_MEMRD = 151;

  busT  exBus;
  busT  sb[$];
  busT  model;
  busT  exp;
  logic expStall;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .Reset(Reset), .Instruction(Instruction), .PCPlus4(PCPlus4),
    .InValid(InValid), .Flush(Flush), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .Stall(Stall),
    .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExMemWrite(ExMemWrite), .ExMemtoReg(ExMemtoReg), .ExALUSrc(ExALUSrc),
    .ExRegDst(ExRegDst), .ExBranch(ExBranch), .ExIllegal(ExIllegal),
    .ExALUOp(ExALUOp), .ExPCPlus4(ExPCPlus4), .ExReadData1(ExReadData1),
    .ExReadData2(ExReadData2), .ExImmediate(ExImmediate), .ExRs(ExRs),
    .ExRt(ExRt), .ExRd(ExRd)
  );

  assign exBus = {ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg, ExALUSrc,
                  ExRegDst, ExBranch, ExIllegal, ExALUOp, ExPCPlus4, ExReadData1,
                  ExReadData2, ExImmediate, ExRs, ExRt, ExRd};

  // Reference model: stall from the modelled EX contents, then next EX contents.
  task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic iv, input logic fl);
    logic [5:0] op;
    logic [4:0] rs, rt, mRt;
    logic rw, mr, mw, m2r, as, rdst, br, ill;
    logic [1:0] ao;
    Reset = rst; Instruction = ins; PCPlus4 = pc; ReadData1 = d1; ReadData2 = d2;
    InValid = iv; Flush = fl;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; mRt = model[9:5];
    expStall = model[B_VALID] & model[B_MEMRD] & (mRt != 0) & iv & ~fl &
               ((mRt == rs) | (mRt == rt));
    {rw, mr, mw, m2r, as, rdst, br, ill, ao} = '0;
    case (op)
      6'b000000: begin rw = 1; rdst = 1; ao = 2'b10; end
      6'b100011: begin rw = 1; mr = 1; m2r = 1; as = 1; end
      6'b101011: begin mw = 1; as = 1; end
      6'b000100: begin br = 1; ao = 2'b01; end
      6'b001000: begin rw = 1; as = 1; end
      default:   ill = 1;
    endcase
    if (rst || fl || expStall || !iv) model = '0;
    else model = {1'b1, rw, mr, mw, m2r, as, rdst, br, ill, ao, pc, d1, d2,
                  {{16{ins[15]}}, ins[15:0]}, rs, rt, ins[15:11]};
    sb.push_back(model);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h00221820, 32'h104, 32'h11, 32'h22, 1'b1, 1'b0);
      tick();
      exp = sb.pop_front();
      checks++;
      if (exBus !== exp || exBus !== '0) begin
        errors++; $display("FAIL reset_ex: got %h want %h", exBus, exp);
      end
      checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
    end
    @(negedge clk);
    drive(1'b0, 32'h00221820, 32'h104, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    exp = sb.pop_front();
    checks++;
    if (exBus !== exp || ExValid !== 1'b1 || ExRegDst !== 1'b1 || ExALUOp !== 2'b10) begin
      errors++; $display("FAIL reset_release_add: got %h want %h", exBus, exp);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ins [3] = '{32'h8C080004, 32'h01014820, 32'h01014820};
    logic        stl [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, ins[i], 32'h200 + 32'(4 * i), 32'h5, 32'h7, 1'b1, 1'b0);
      #1;
      checks++;
      if (Stall !== expStall || Stall !== stl[i]) begin
        errors++; $display("FAIL load_use_stall[%0d]: got %b want %b", i, Stall, stl[i]);
      end
      tick();
      exp = sb.pop_front();
      checks++;
      if (exBus !== exp) begin
        errors++; $display("FAIL load_use_ex[%0d]: got %h want %h", i, exBus, exp);
      end
    end
    checks++;
    if (ExRs !== 5'd8 || ExValid !== 1'b1) begin
      errors++; $display("FAIL load_use_issue: got rs %0d vld %b want 8 1", ExRs, ExValid);
    end
  endtask

  task automatic test_zero_dest();
    logic [31:0] ins [2] = '{32'h8C200000, 32'h00001020};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, ins[i], 32'h300, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL zero_dest_stall[%0d]: got %b want 0", i, Stall); end
      tick();
      exp = sb.pop_front();
      checks++;
      if (exBus !== exp) begin errors++; $display("FAIL zero_dest_ex[%0d]: got %h want %h", i, exBus, exp); end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1'b0, 32'h8C080004, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    exp = sb.pop_front();
    checks++;
    if (exBus !== exp) begin errors++; $display("FAIL flush_lw: got %h want %h", exBus, exp); end
    @(negedge clk);
    drive(1'b0, 32'h01014820, 32'h404, 32'h3, 32'h4, 1'b1, 1'b1);
    #1;
    checks++;
    if (Stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", Stall); end
    tick();
    exp = sb.pop_front();
    checks++;
    if (exBus !== exp || exBus !== '0) begin errors++; $display("FAIL flush_bubble: got %h want %h", exBus, exp); end
  endtask

  task automatic test_immediate();
    @(negedge clk);
    drive(1'b0, 32'h20258000, 32'h500, 32'h00000010, 32'h99, 1'b1, 1'b1 ^ 1'b1);
    tick();
    exp = sb.pop_front();
    checks++;
    if (exBus !== exp || ExImmediate !== 32'hFFFF8000 || ExALUSrc !== 1'b1 ||
        ExReadData1 !== 32'h00000010) begin
      errors++; $display("FAIL addi_imm: got imm %h src %b rd1 %h want FFFF8000 1 00000010",
                         ExImmediate, ExALUSrc, ExReadData1);
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins [4] = '{32'hAC220008, 32'h1022FFFF, 32'hFC221820, 32'h00221820};
    logic        iv  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, ins[i], 32'h600 + 32'(4 * i), 32'hA0 + 32'(i), 32'hB0 + 32'(i), iv[i], 1'b0);
      #1;
      checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL decode_stall[%0d]: got %b want 0", i, Stall); end
      tick();
      exp = sb.pop_front();
      checks++;
      if (exBus !== exp) begin errors++; $display("FAIL decode_ex[%0d]: got %h want %h", i, exBus, exp); end
      if (i == 2) begin
        checks++;
        if (ExIllegal !== 1'b1 || ExValid !== 1'b1 || ExRegWrite !== 1'b0 || ExALUOp !== 2'b00) begin
          errors++; $display("FAIL illegal_op: got ill %b vld %b rw %b want 1 1 0", ExIllegal, ExValid, ExRegWrite);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    drive(1'b0, 32'h8C080004, 32'h700, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h01014820, 32'h704, 32'h1, 32'h2, 1'b1, 1'b0);
      #1;
      checks++;
      if (Stall !== expStall) begin
        errors++; $display("FAIL rst_stall[%0d]: got %b want %b", i, Stall, expStall);
      end
      tick();
      exp = sb.pop_front();
      checks++;
      if (exBus !== exp) begin errors++; $display("FAIL rst_stall_ex[%0d]: got %h want %h", i, exBus, exp); end
    end
  endtask

  initial begin
    model = '0;
    Reset = 1'b1; Instruction = '0; PCPlus4 = '0; ReadData1 = '0; ReadData2 = '0;
    InValid = 1'b0; Flush = 1'b0;
    test_reset();
    test_load_use();
    test_zero_dest();
    test_flush();
    test_immediate();
    test_decode();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
